mem_stage_bus_unit: RTL and testbench
=====================================

Name: mem_stage_bus_unit

Overview:
Parametrised MEM-stage bus master for the 5-stage pipeline. It replaces the direct ExMem-to-MIO wiring, which has no wait states and only handles whole words. It runs one load/store per request over the MIO bus, waits on MIO_ready with a timeout, and handles byte, half and word accesses with sign or zero extension. It holds the pipeline through mem_stall until the access completes.

Parameters:
DATA_W, 32, bus data width; legal values are 32 or 64.
ADDR_W, 32, address width.
TIMEOUT_CYC, 255, maximum number of ACCESS cycles spent waiting for MIO_ready before a bus error.
TO_W, 8, width of the wait counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
clk  in  1  clock; all logic updates on the rising edge.
rst  in  1  reset, synchronous, active-high.
cpu_en  in  1  global enable; when low, all state holds.
req_valid  in  1  MEM stage holds a load or store.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 dword (dword legal only when DATA_W=64).
req_signed  in  1  sign-extend load data.
req_addr  in  ADDR_W  byte address (the ALU output).
req_wdata  in  DATA_W  store data (register rt).
MIO_ready  in  1  bus ready / acknowledge.
Data_in  in  DATA_W  bus read data.
Address_out  out  ADDR_W  bus address.
Data_out  out  DATA_W  bus write data, lane-replicated.
byte_en  out  DATA_W/8  byte-lane strobes.
mem_ifWriteMem  out  1  bus write strobe.
CPU_MIO  out  1  bus request.
mem_stall  out  1  hold signal for the IF/ID/EX/MEM stages.
rdata_valid  out  1  single-cycle pulse: load or store completed.
rdata  out  DATA_W  extended load result; holds until the next load completes.
misaligned  out  1  single-cycle pulse: alignment or size fault.
bus_timeout  out  1  single-cycle pulse: MIO_ready timeout.

Behaviour:
- Reset: the FSM enters IDLE, the wait counter is cleared, and every output is 0. Reset during ACCESS deasserts CPU_MIO and mem_ifWriteMem at that edge and drops the in-flight request; no completion pulse is produced.
- cpu_en=0 freezes the FSM, the wait counter and all registered outputs. mem_stall keeps its current value.
- FSM states: IDLE, ACCESS, DONE, ERR.
- IDLE, mem_stall: combinationally equal to req_valid.
- IDLE, request with a fault: a fault is req_size=01 with addr[0]≠0, req_size=10 with addr[1:0]≠0, req_size=11 with addr[2:0]≠0, or req_size=11 when DATA_W=32. The FSM goes to ERR and no bus cycle is issued.
- IDLE, request without a fault: the FSM goes to ACCESS and registers, in the same edge:
  - Address_out = req_addr.
  - Data_out = req_wdata[size-1:0] replicated across all lanes.
  - byte_en = size mask shifted by the lane index addr[log2(DATA_W/8)-1:0].
  - CPU_MIO = 1.
  - mem_ifWriteMem = req_write.
  - wait counter = 0.
- ACCESS, mem_stall: 1.
- ACCESS, MIO_ready=1:
  - For a load, capture Data_in, shift right by the lane index × 8, then sign- or zero-extend from the access size into rdata.
  - Clear CPU_MIO, mem_ifWriteMem and byte_en.
  - Go to DONE.
- ACCESS, MIO_ready=0: the wait counter increments. When the counter equals TIMEOUT_CYC, clear the bus signals and go to ERR. MIO_ready=1 in the same cycle takes priority over the timeout.
- DONE: mem_stall=0 and rdata_valid=1, then the FSM returns to IDLE unconditionally.
- ERR: mem_stall=0 and exactly one of misaligned or bus_timeout is 1, then the FSM returns to IDLE.
- A request held on req_valid in the cycle after DONE or ERR is treated as a new request; the pipeline must have advanced.
- Minimum latency with MIO_ready held high: request seen in cycle 0, ACCESS in cycle 1, rdata_valid in cycle 2. mem_stall is high in cycles 0 and 1.
- Throughput: at most one access per 3 cycles.
- A store sets rdata_valid but leaves rdata unchanged.

Optional Feature:
BUS_ERR_ADDR_EN
- When defined: extra ports err_addr (out, ADDR_W) and err_clr (in, 1) exist.
  - On entry to ERR, err_addr captures the faulting address, but only if err_addr is currently 0; the first fault wins.
  - err_clr=1 clears err_addr to 0 on the next edge. err_clr has priority over a capture in the same cycle.
  - err_addr resets to 0.
- When undefined: neither port exists and there is no capture logic.

Test Plan:
1. Word load, addr 0x0000_0010, MIO_ready=1, Data_in=0xDEAD_BEEF -> byte_en=4'b1111 in cycle 1; rdata=0xDEAD_BEEF with rdata_valid in cycle 2; mem_stall high in cycles 0 and 1.
2. Signed byte load, addr 0x13, Data_in=0x80_00_00_00 -> rdata=0xFFFF_FF80. The same access unsigned -> rdata=0x0000_0080.
3. Half store, addr 0x22, req_wdata=0x0000_1234 -> Data_out=0x1234_1234, byte_en=4'b1100, mem_ifWriteMem=1 for exactly one cycle.
4. Word load, addr 0x0000_0006 -> misaligned pulse; CPU_MIO never asserted. With BUS_ERR_ADDR_EN: err_addr=0x6.
5. TIMEOUT_CYC=4 with MIO_ready held at 0 -> bus_timeout pulses after 4 ACCESS cycles and CPU_MIO drops. Repeat with MIO_ready=1 in the 4th ACCESS cycle -> normal completion, no bus_timeout.
6. Set cpu_en=0 for 3 cycles during ACCESS, then rst=1 for one cycle -> state frozen while cpu_en is low; after reset all outputs are 0, the FSM is in IDLE, and no rdata_valid pulse occurs.

Source files
------------

// File: rtl/mem_stage_bus_unit.sv
// mem_stage_bus_unit: MEM-stage bus master with wait states, timeout and
// byte/half/word(/dword) accesses with sign or zero extension of loads.
//
// Ports:
//   clk, rst (sync, active-high), cpu_en (global hold)
//   req_*       : load/store request from the MEM stage
//   MIO_ready, Data_in           : bus acknowledge and read data
//   Address_out, Data_out, byte_en, mem_ifWriteMem, CPU_MIO : bus master
//   mem_stall   : pipeline hold while an access is pending
//   rdata_valid, rdata           : completion pulse and extended load data
//   misaligned, bus_timeout      : single-cycle fault pulses
// Optional macro BUS_ERR_ADDR_EN adds err_addr (first faulting address,
// sticky until err_clr) and err_clr.
module mem_stage_bus_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_en,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic                MIO_ready,
    input  logic [DATA_W-1:0]   Data_in,
    output logic [ADDR_W-1:0]   Address_out,
    output logic [DATA_W-1:0]   Data_out,
    output logic [DATA_W/8-1:0] byte_en,
    output logic                mem_ifWriteMem,
    output logic                CPU_MIO,
    output logic                mem_stall,
    output logic                rdata_valid,
    output logic [DATA_W-1:0]   rdata,
    output logic                misaligned,
    output logic                bus_timeout
`ifdef BUS_ERR_ADDR_EN
    ,
    output logic [ADDR_W-1:0]   err_addr,
    input  logic                err_clr
`endif
);

    localparam int NB     = DATA_W / 8;
    localparam int LANE_W = $clog2(NB);
    localparam logic DW32 = (DATA_W == 32);
    // Timeout fires on the ready-low cycle that would bring the count
    // to TIMEOUT_CYC, i.e. after exactly TIMEOUT_CYC waiting cycles.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [TO_W-1:0]   r_cnt;
    logic [1:0]        r_size;
    logic              r_signed;
    logic              r_err_to;

    logic              w_fault;
    logic [NB-1:0]     w_mask;
    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_wrep;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_ext;
    logic [LANE_W-1:0] w_lane;
    logic [LANE_W-1:0] w_rlane;

    assign w_lane  = req_addr[LANE_W-1:0];
    assign w_rlane = Address_out[LANE_W-1:0];

    assign w_fault = ((req_size == 2'b01) && req_addr[0])
                   || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                   || ((req_size == 2'b11)
                       && ((req_addr[2:0] != 3'b000) || DW32));

    always_comb begin
        w_mask = '0;
        w_wrep = req_wdata;
        unique case (req_size)
            2'b00: begin
                w_mask = NB'(1);
                w_wrep = {NB{req_wdata[7:0]}};
            end
            2'b01: begin
                w_mask = NB'(3);
                w_wrep = {(NB/2){req_wdata[15:0]}};
            end
            2'b10: begin
                w_mask = NB'(15);
                w_wrep = {(NB/4){req_wdata[31:0]}};
            end
            default: begin
                w_mask = '1;
                w_wrep = req_wdata;
            end
        endcase
        w_be = w_mask << w_lane;
    end

    // Load data: move the addressed lane down to bit 0, then extend.
    assign w_shifted = Data_in >> {w_rlane, 3'b000};

    always_comb begin
        w_ext = w_shifted;
        unique case (r_size)
            2'b00: w_ext = r_signed ? DATA_W'($signed(w_shifted[7:0]))
                                    : DATA_W'(w_shifted[7:0]);
            2'b01: w_ext = r_signed ? DATA_W'($signed(w_shifted[15:0]))
                                    : DATA_W'(w_shifted[15:0]);
            2'b10: w_ext = r_signed ? DATA_W'($signed(w_shifted[31:0]))
                                    : DATA_W'(w_shifted[31:0]);
            default: w_ext = w_shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (cpu_en) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        mem_stall   = 1'b0;
        rdata_valid = 1'b0;
        misaligned  = 1'b0;
        bus_timeout = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                mem_stall = req_valid;
                if (req_valid) begin
                    w_next = w_fault ? S_ERR : S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_stall = 1'b1;
                if (MIO_ready) begin
                    w_next = S_DONE;
                end else if (r_cnt == TO_LAST) begin
                    w_next = S_ERR;
                end
            end
            S_DONE: begin
                rdata_valid = 1'b1;
                w_next      = S_IDLE;
            end
            default: begin
                misaligned  = ~r_err_to;
                bus_timeout = r_err_to;
                w_next      = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Address_out    <= '0;
            Data_out       <= '0;
            byte_en        <= '0;
            mem_ifWriteMem <= 1'b0;
            CPU_MIO        <= 1'b0;
            rdata          <= '0;
            r_cnt          <= '0;
            r_size         <= 2'b00;
            r_signed       <= 1'b0;
            r_err_to       <= 1'b0;
        end else if (cpu_en) begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid && w_fault) begin
                        r_err_to <= 1'b0;
                    end else if (req_valid) begin
                        Address_out    <= req_addr;
                        Data_out       <= w_wrep;
                        byte_en        <= w_be;
                        CPU_MIO        <= 1'b1;
                        mem_ifWriteMem <= req_write;
                        r_cnt          <= '0;
                        r_size         <= req_size;
                        r_signed       <= req_signed;
                    end
                end
                S_ACCESS: begin
                    if (MIO_ready) begin
                        if (!mem_ifWriteMem) begin
                            rdata <= w_ext;
                        end
                        byte_en        <= '0;
                        CPU_MIO        <= 1'b0;
                        mem_ifWriteMem <= 1'b0;
                    end else if (r_cnt == TO_LAST) begin
                        byte_en        <= '0;
                        CPU_MIO        <= 1'b0;
                        mem_ifWriteMem <= 1'b0;
                        r_err_to       <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef BUS_ERR_ADDR_EN
    // A misaligned fault reports the request address; a timeout reports
    // the address still on the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_addr <= '0;
        end else if (cpu_en) begin
            if (err_clr) begin
                err_addr <= '0;
            end else if ((w_next == S_ERR) && (r_state != S_ERR)
                         && (err_addr == '0)) begin
                err_addr <= (r_state == S_IDLE) ? req_addr : Address_out;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_bus_unit.sv
// tb_mem_stage_bus_unit: directed vector table plus multi-cycle sequences
// for timeout, freeze and reset-during-access behaviour.
module tb_mem_stage_bus_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        MIO_ready;
    logic [31:0] Data_in;
    logic [31:0] Address_out;
    logic [31:0] Data_out;
    logic [3:0]  byte_en;
    logic        mem_ifWriteMem;
    logic        CPU_MIO;
    logic        mem_stall;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic        misaligned;
    logic        bus_timeout;
`ifdef BUS_ERR_ADDR_EN
    logic [31:0] err_addr;
    logic        err_clr;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_stage_bus_unit #(
        .DATA_W(32),
        .ADDR_W(32),
        .TIMEOUT_CYC(4),
        .TO_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu_en(cpu_en),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_size(req_size),
        .req_signed(req_signed),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .MIO_ready(MIO_ready),
        .Data_in(Data_in),
        .Address_out(Address_out),
        .Data_out(Data_out),
        .byte_en(byte_en),
        .mem_ifWriteMem(mem_ifWriteMem),
        .CPU_MIO(CPU_MIO),
        .mem_stall(mem_stall),
        .rdata_valid(rdata_valid),
        .rdata(rdata),
        .misaligned(misaligned),
        .bus_timeout(bus_timeout)
`ifdef BUS_ERR_ADDR_EN
        ,
        .err_addr(err_addr),
        .err_clr(err_clr)
`endif
    );

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] din;
        logic        flt;
        logic [3:0]  be;
        logic [31:0] dout;
        logic [31:0] rd;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] di,
                         input logic rdy);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        Data_in    = di;
        MIO_ready  = rdy;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_addr"}, Address_out, 0);
        chk({nm, "_dout"}, Data_out, 0);
        chk({nm, "_be"}, byte_en, 0);
        chk({nm, "_we"}, mem_ifWriteMem, 0);
        chk({nm, "_mio"}, CPU_MIO, 0);
        chk({nm, "_stall"}, mem_stall, 0);
        chk({nm, "_rv"}, rdata_valid, 0);
        chk({nm, "_rdata"}, rdata, 0);
        chk({nm, "_mis"}, misaligned, 0);
        chk({nm, "_to"}, bus_timeout, 0);
    endtask

    initial begin
        //        wr  sz     sg  addr   wdata         din          flt be       dout          rd
        tv[0]  = '{0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF};
        tv[1]  = '{0, 2'b00, 1, 32'h13, 32'h0,        32'h80000000, 0, 4'b1000, 32'h0,        32'hFFFFFF80};
        tv[2]  = '{0, 2'b00, 0, 32'h13, 32'h0,        32'h80000000, 0, 4'b1000, 32'h0,        32'h00000080};
        tv[3]  = '{1, 2'b01, 0, 32'h22, 32'h00001234, 32'h0,        0, 4'b1100, 32'h12341234, 32'h00000080};
        tv[4]  = '{0, 2'b10, 0, 32'h06, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        32'h0};
        tv[5]  = '{0, 2'b01, 1, 32'h02, 32'h0,        32'h80017FFF, 0, 4'b1100, 32'h0,        32'hFFFF8001};
        tv[6]  = '{0, 2'b00, 0, 32'h01, 32'h0,        32'h0000A500, 0, 4'b0010, 32'h0,        32'h000000A5};
        tv[7]  = '{1, 2'b00, 0, 32'h03, 32'h000000AB, 32'h0,        0, 4'b1000, 32'hABABABAB, 32'h000000A5};
        tv[8]  = '{0, 2'b11, 0, 32'h08, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        32'h0};
        tv[9]  = '{0, 2'b01, 0, 32'h01, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        32'h0};
        tv[10] = '{1, 2'b10, 0, 32'h04, 32'hCAFEF00D, 32'h0,        0, 4'b1111, 32'hCAFEF00D, 32'h000000A5};
        tv[11] = '{0, 2'b10, 1, 32'h00, 32'h0,        32'h12345678, 0, 4'b1111, 32'h0,        32'h12345678};

        rst        = 1'b1;
        cpu_en     = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        MIO_ready  = 1'b0;
        Data_in    = '0;
`ifdef BUS_ERR_ADDR_EN
        err_clr    = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        #2;
        chk_all_zero("reset");
`ifdef BUS_ERR_ADDR_EN
        chk("reset_err_addr", err_addr, 0);
`endif

        for (int i = 0; i < 12; i++) begin
            tick();
            drive(tv[i].wr, tv[i].sz, tv[i].sg, tv[i].addr,
                  tv[i].wdata, tv[i].din, 1'b1);
            #2;
            chk($sformatf("v%0d_stall0", i), mem_stall, 1);
            tick();
            req_valid = 1'b0;
            #2;
            if (tv[i].flt) begin
                chk($sformatf("v%0d_mis", i), misaligned, 1);
                chk($sformatf("v%0d_to", i), bus_timeout, 0);
                chk($sformatf("v%0d_mio", i), CPU_MIO, 0);
                chk($sformatf("v%0d_stall", i), mem_stall, 0);
            end else begin
                chk($sformatf("v%0d_mio", i), CPU_MIO, 1);
                chk($sformatf("v%0d_be", i), byte_en, tv[i].be);
                chk($sformatf("v%0d_dout", i), Data_out, tv[i].dout);
                chk($sformatf("v%0d_we", i), mem_ifWriteMem, tv[i].wr);
                chk($sformatf("v%0d_addr", i), Address_out, tv[i].addr);
                chk($sformatf("v%0d_stall1", i), mem_stall, 1);
                chk($sformatf("v%0d_rv1", i), rdata_valid, 0);
                tick();
                #2;
                chk($sformatf("v%0d_rv", i), rdata_valid, 1);
                chk($sformatf("v%0d_rdata", i), rdata, tv[i].rd);
                chk($sformatf("v%0d_mio2", i), CPU_MIO, 0);
                chk($sformatf("v%0d_we2", i), mem_ifWriteMem, 0);
                chk($sformatf("v%0d_be2", i), byte_en, 0);
                chk($sformatf("v%0d_stall2", i), mem_stall, 0);
                chk($sformatf("v%0d_mis2", i), misaligned, 0);
            end
        end
`ifdef BUS_ERR_ADDR_EN
        chk("err_addr_first", err_addr, 32'h6);
`endif

        // Timeout after four ACCESS cycles with MIO_ready low.
        tick();
        drive(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
        #2;
        for (int k = 1; k <= 4; k++) begin
            tick();
            req_valid = 1'b0;
            #2;
            chk($sformatf("to_mio_c%0d", k), CPU_MIO, 1);
            chk($sformatf("to_stall_c%0d", k), mem_stall, 1);
            chk($sformatf("to_pulse_c%0d", k), bus_timeout, 0);
        end
        tick();
        #2;
        chk("to_pulse", bus_timeout, 1);
        chk("to_mis", misaligned, 0);
        chk("to_mio_drop", CPU_MIO, 0);
        chk("to_stall", mem_stall, 0);
        chk("to_rv", rdata_valid, 0);
        tick();
        #2;
        chk("to_pulse_end", bus_timeout, 0);
`ifdef BUS_ERR_ADDR_EN
        chk("err_addr_kept", err_addr, 32'h6);
`endif

        // Ready in the fourth ACCESS cycle beats the timeout.
        tick();
        drive(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'h0BADF00D, 1'b0);
        #2;
        for (int k = 1; k <= 4; k++) begin
            tick();
            req_valid = 1'b0;
            if (k == 4) MIO_ready = 1'b1;
            #2;
            chk($sformatf("late_mio_c%0d", k), CPU_MIO, 1);
        end
        tick();
        #2;
        chk("late_rv", rdata_valid, 1);
        chk("late_to", bus_timeout, 0);
        chk("late_rdata", rdata, 32'h0BADF00D);
        MIO_ready = 1'b0;

        // Freeze during ACCESS, then reset drops the access.
        tick();
        drive(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 32'h11112222, 1'b0);
        #2;
        tick();
        req_valid = 1'b0;
        cpu_en    = 1'b0;
        MIO_ready = 1'b1;
        #2;
        chk("frz_mio_c1", CPU_MIO, 1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            #2;
            chk($sformatf("frz_mio_c%0d", k), CPU_MIO, 1);
            chk($sformatf("frz_stall_c%0d", k), mem_stall, 1);
            chk($sformatf("frz_rv_c%0d", k), rdata_valid, 0);
            chk($sformatf("frz_rdata_c%0d", k), rdata, 32'h0BADF00D);
        end
        cpu_en = 1'b1;
        rst    = 1'b1;
        tick();
        rst       = 1'b0;
        MIO_ready = 1'b0;
        #2;
        chk_all_zero("rst_acc");
`ifdef BUS_ERR_ADDR_EN
        chk("rst_err_addr", err_addr, 0);
`endif
        tick();
        #2;
        chk("rst_rv_after", rdata_valid, 0);
        chk("rst_mio_after", CPU_MIO, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
